// File: rtl/skid_reg_stage.sv
// Registered valid/ready pipeline stage with a one-entry skid buffer.
// in_ready comes only from state flops, which breaks the out_ready -> in_ready timing path.
module skid_reg_stage #(
    parameter int                 WIDTH       = 8,
    parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
    parameter int                 CNT_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     out_data_q, out_data_d;
    logic [WIDTH-1:0]     skid_q, skid_d;
    logic [CNT_WIDTH-1:0] stall_q, stall_d;
    logic                 in_fire;
    logic                 out_fire;

    assign out_valid   = (state_q != EMPTY);
    assign in_ready    = (state_q != FULL) & ~reset;
    assign out_data    = out_data_q;
    assign stall_count = stall_q;
    assign in_fire     = in_valid & in_ready;
    assign out_fire    = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            out_data_q <= RESET_VALUE;
            skid_q     <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            out_data_q <= out_data_d;
            skid_q     <= skid_d;
            stall_q    <= stall_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        out_data_d = out_data_q;
        skid_d     = skid_q;
        stall_d    = stall_q;

        if (out_valid && !out_ready && (stall_q != CNT_MAX)) begin
            stall_d = stall_q + 1'b1;
        end

        if (flush) begin
            // Flush wins over every transition; a concurrent out_fire was already taken downstream.
            state_d    = EMPTY;
            out_data_d = RESET_VALUE;
            skid_d     = '0;
            stall_d    = '0;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        out_data_d = in_data;
                        state_d    = BUSY;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        out_data_d = in_data;
                    end else if (in_fire) begin
                        skid_d  = in_data;
                        state_d = FULL;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        out_data_d = skid_q;
                        state_d    = BUSY;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_skid_reg_stage.sv
// Self-checking bench for skid_reg_stage: directed scenarios plus a randomized scoreboard run.
// A reference queue models occupancy, ordering, flush and the saturating stall counter.
module tb_skid_reg_stage;

    localparam int               WIDTH       = 8;
    localparam logic [WIDTH-1:0] RESET_VALUE = 8'h5A;
    localparam int               CNT_WIDTH   = 4;
    localparam int               CNT_MAX     = (1 << CNT_WIDTH) - 1;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 flush;
    logic [WIDTH-1:0]     in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [CNT_WIDTH-1:0] stall_count;

    int n_cmp = 0;
    int n_err = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               stall_m = 0;

    skid_reg_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .CNT_WIDTH   (CNT_WIDTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .flush       (flush),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .stall_count (stall_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change at posedge+1; the model evaluates the upcoming edge at negedge.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            stall_m = 0;
        end else begin
            check("out_valid", out_valid, exp_q.size() != 0);
            check("in_ready", in_ready, exp_q.size() < 2);
            check("stall_count", stall_count, stall_m);
            if (exp_q.size() != 0) begin
                check("out_data", out_data, exp_q[0]);
                if (!out_ready && stall_m < CNT_MAX) stall_m++;
            end
            begin
                logic model_ready;
                model_ready = exp_q.size() < 2;
                if (exp_q.size() != 0 && out_ready) begin
                    $display("xfer out %02h", exp_q[0]);
                    void'(exp_q.pop_front());
                end
                if (flush) begin
                    exp_q.delete();
                    stall_m = 0;
                end else if (in_valid && model_ready) begin
                    $display("xfer in  %02h", in_data);
                    exp_q.push_back(in_data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        flush     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_data", out_data, RESET_VALUE);
        check("rst_stall", stall_count, 0);
        step();
        step();
        reset = 1'b0;
        step();

        // Streaming at full rate
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h11; step();
        check("t1_lat", out_data, 8'h11);
        in_data   = 8'h22; step();
        check("t1_d22", out_data, 8'h22);
        in_data   = 8'h33; step();
        check("t1_d33", out_data, 8'h33);
        in_valid  = 1'b0;  step();
        check("t1_stall", stall_count, 0);

        // Fill the skid, then drain
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hA1; step();
        in_data   = 8'hA2; step();
        in_valid  = 1'b0;
        check("t2_full_ready", in_ready, 0);
        check("t2_hold", out_data, 8'hA1);
        step();
        check("t2_stable", out_data, 8'hA1);
        out_ready = 1'b1; step();
        check("t2_second", out_data, 8'hA2);
        step();
        check("t2_drained", out_valid, 0);

        // Stall counter saturation, then flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC3; step();
        in_valid  = 1'b0;
        repeat (20) step();
        check("t3_sat", stall_count, CNT_MAX);
        flush = 1'b1; step();
        flush = 1'b0;
        check("t3_stall_clr", stall_count, 0);
        check("t3_out_data", out_data, RESET_VALUE);
        check("t3_out_valid", out_valid, 0);

        // Flush while FULL with a pending input
        in_valid = 1'b1;
        in_data  = 8'h01; step();
        in_data  = 8'h02; step();
        in_data  = 8'h03;
        flush    = 1'b1; step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("t4_empty", out_valid, 0);
        out_ready = 1'b1;
        repeat (3) step();
        check("t4_none", out_valid, 0);

        // Asynchronous reset mid-cycle while BUSY
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77; step();
        in_valid  = 1'b0;
        check("t5_busy", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        check("t5_async_valid", out_valid, 0);
        check("t5_async_ready", in_ready, 0);
        check("t5_async_data", out_data, RESET_VALUE);
        step();
        reset = 1'b0;
        out_ready = 1'b1;
        step();
        check("t5_ready_after", in_ready, 1);
        check("t5_no_77", out_valid, 0);

        // Randomized traffic against the scoreboard
        for (int i = 0; i < 10000; i++) begin
            step();
            in_valid  = $urandom_range(0, 1);
            in_data   = WIDTH'($urandom);
            out_ready = $urandom_range(0, 1);
            flush     = ($urandom_range(0, 63) == 0);
            if ((i % 16) == 0) begin
                logic r0;
                #1;
                r0 = in_ready;
                out_ready = ~out_ready;
                #1;
                check("comb_path", in_ready, r0);
                out_ready = ~out_ready;
            end
        end
        step();
        in_valid  = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        repeat (4) step();
        check("drain_empty", exp_q.size(), 0);
        check("drain_valid", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
